// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store sequencer.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
//
// Holds the access-size codes and the sequencer state encoding. Pipeline control
// decode imports the same package, so size codes stay consistent across the pipeline.
package mem_access_unit_pkg;

    // Access size codes carried on req_size. Code 2'b11 behaves as a word access.
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_WRITE  = 3'd2,
        ST_RMW_RD = 3'd3,
        ST_RMW_WR = 3'd4,
        ST_RESP   = 3'd5
    } state_t;

    // Request fields latched at accept. The address is held separately because its
    // width is a module parameter.
    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        sign;
        logic [31:0] wdata;
    } req_t;

    // Both 2'b10 and 2'b11 are full-word accesses.
    function automatic logic is_word(input logic [1:0] size);
        return size[1];
    endfunction

endpackage

// File: rtl/mem_access_unit_align.sv
// Byte/halfword lane extract with sign/zero extension, and store lane merge.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the outputs follow the inputs.
//
// Ports:
//   size, sign, addr_lo  access size, load extension mode, byte offset in the word
//   load_word            word read from dm; the load lane is extracted from it
//   merge_word           old dm word that a sub-word store is merged into
//   store_data           right-justified store data
//   load_data            extended load result
//   merged_word          merge_word with the addressed lane(s) replaced
module mem_access_unit_align
    import mem_access_unit_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] load_word,
    input  logic [31:0] merge_word,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    // Physical lane numbers, counted from bit 0 of the word. Big-endian mirrors the
    // byte order, so byte offset k maps to physical byte 3-k (= ~k for two bits).
    logic [1:0] byte_lane;
    logic       half_lane;
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    assign byte_lane = BIG_ENDIAN ? ~addr_lo    : addr_lo;
    assign half_lane = BIG_ENDIAN ? ~addr_lo[1] : addr_lo[1];

    assign byte_val = load_word[{byte_lane, 3'b000} +: 8];
    assign half_val = load_word[{half_lane, 4'b0000} +: 16];

    always_comb begin
        load_data = load_word;
        case (size)
            SIZE_B:  load_data = {{24{sign & byte_val[7]}}, byte_val};
            SIZE_H:  load_data = {{16{sign & half_val[15]}}, half_val};
            default: load_data = load_word;
        endcase
    end

    always_comb begin
        merged_word = merge_word;
        case (size)
            SIZE_B:  merged_word[{byte_lane, 3'b000} +: 8]   = store_data[7:0];
            SIZE_H:  merged_word[{half_lane, 4'b0000} +: 16] = store_data[15:0];
            default: merged_word = store_data;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the MEM stage and a word-only data memory (dm).
// Latency (accept cycle to resp_valid cycle): load 2, word store 2, sub-word store 3.
// Backpressure: req_ready low while busy; no response backpressure (resp_* is a pulse).
//
// Ports:
//   clk, rst_n                  clock and asynchronous active-low reset
//   req_valid/req_ready         request handshake; accepted when both are high
//   req_we/size/sign/addr/wdata request fields, sampled only at accept
//   resp_valid/resp_rdata       one-cycle completion pulse and extended load data
//   exc_misalign                misaligned-access flag (only with MISALIGN_EXC_EN)
//   dm_addr/ctrl_r/ctrl_w       word-aligned dm address and read/write enables
//   dm_wdata/dm_rdata           dm write data and combinational read data
//
// Build option: define MISALIGN_EXC_EN to trap misaligned half/word accesses
// instead of silently masking the low address bits.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_sign,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
`ifdef MISALIGN_EXC_EN
    output logic              exc_misalign,
`endif
    output logic [31:0]       dm_addr,
    output logic              dm_ctrl_r,
    output logic              dm_ctrl_w,
    output logic [31:0]       dm_wdata,
    input  logic [31:0]       dm_rdata
);

    state_t            state_q, state_d;
    req_t              req_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       merge_q;
    logic              accept;
    logic              misalign;
    logic [31:0]       load_data;
    logic [31:0]       merged_word;
    logic              resp_valid_q;
    logic [31:0]       resp_rdata_q;

    assign accept = req_valid && req_ready;

`ifdef MISALIGN_EXC_EN
    logic exc_q;
    assign misalign = ((req_size == SIZE_H) && req_addr[0]) ||
                      (is_word(req_size) && (req_addr[1:0] != 2'b00));
    assign exc_misalign = exc_q;
`else
    assign misalign = 1'b0;
`endif

    // dm is word-addressed; the byte offset only steers lanes.
    assign dm_addr    = 32'({addr_q[ADDR_W-1:2], 2'b00});
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;

    mem_access_unit_align #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_align (
        .size        (req_q.size),
        .sign        (req_q.sign),
        .addr_lo     (addr_q[1:0]),
        .load_word   (dm_rdata),
        .merge_word  (merge_q),
        .store_data  (req_q.wdata),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    // State register. The async reset also kills dm_ctrl_w at once, because the write
    // enable decodes from state; an interrupted RMW therefore never writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (misalign) begin
                        state_d = ST_RESP;
                    end else if (!req_we) begin
                        state_d = ST_LOAD;
                    end else if (is_word(req_size)) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_RMW_RD;
                    end
                end
            end
            ST_LOAD, ST_WRITE, ST_RMW_WR: state_d = ST_RESP;
            ST_RMW_RD:                    state_d = ST_RMW_WR;
            ST_RESP:                      state_d = ST_IDLE;
            default:                      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        dm_ctrl_r = 1'b0;
        dm_ctrl_w = 1'b0;
        dm_wdata  = '0;
        case (state_q)
            ST_IDLE:            req_ready = 1'b1;
            ST_LOAD, ST_RMW_RD: dm_ctrl_r = 1'b1;
            ST_WRITE: begin
                dm_ctrl_w = 1'b1;
                dm_wdata  = req_q.wdata;
            end
            ST_RMW_WR: begin
                dm_ctrl_w = 1'b1;
                dm_wdata  = merged_word;
            end
            default: ;
        endcase
    end

    // Request latches: inputs are only looked at in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q  <= '0;
            addr_q <= '0;
        end else if (accept) begin
            req_q  <= '{we: req_we, size: req_size, sign: req_sign, wdata: req_wdata};
            addr_q <= req_addr;
        end
    end

    // Old word for the read-modify-write merge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            merge_q <= '0;
        end else if (state_q == ST_RMW_RD) begin
            merge_q <= dm_rdata;
        end
    end

    // Response registers: valid is high exactly while in RESP; data is non-zero only
    // when the response comes from LOAD (stores and traps return 0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            resp_valid_q <= (state_d == ST_RESP);
            resp_rdata_q <= (state_q == ST_LOAD) ? load_data : 32'd0;
        end
    end

`ifdef MISALIGN_EXC_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exc_q <= 1'b0;
        end else begin
            exc_q <= accept && misalign;
        end
    end
`endif

endmodule
